// File: rtl/seg_frame_encoder_pkg.sv
// Shared constants for the segment frame encoder: glyph bytes, segment bit positions, FSM states.
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] GLYPH_0     = 8'hFC;
    localparam logic [7:0] GLYPH_1     = 8'h60;
    localparam logic [7:0] GLYPH_2     = 8'hDA;
    localparam logic [7:0] GLYPH_3     = 8'hF2;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'hB6;
    localparam logic [7:0] GLYPH_6     = 8'hBE;
    localparam logic [7:0] GLYPH_7     = 8'hE0;
    localparam logic [7:0] GLYPH_8     = 8'hFE;
    localparam logic [7:0] GLYPH_9     = 8'hF6;
    localparam logic [7:0] GLYPH_A     = 8'hEE;
    localparam logic [7:0] GLYPH_B     = 8'h3E;
    localparam logic [7:0] GLYPH_C     = 8'h9C;
    localparam logic [7:0] GLYPH_D     = 8'h7A;
    localparam logic [7:0] GLYPH_E     = 8'h9E;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_DASH  = 8'h02;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/seg_frame_encoder_if.sv
// Frame-load and segment-stream bus of the encoder; blink_mask_i exists only with SEG_BLINK_EN.
interface seg_frame_encoder_if #(parameter int DIGITS = 8);
    logic                  load_i;
    logic [4*DIGITS-1:0]   digits_i;
    logic [DIGITS-1:0]     dp_i;
    logic                  hex_mode_i;
    logic                  lzb_i;
`ifdef SEG_BLINK_EN
    logic [DIGITS-1:0]     blink_mask_i;
`endif
    logic                  busy_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [3:0]            out_addr_o;
    logic [7:0]            out_data_o;
    logic                  out_last_o;
    logic                  done_o;

    modport slave (
        input  load_i, digits_i, dp_i, hex_mode_i, lzb_i, out_ready_i,
`ifdef SEG_BLINK_EN
        input  blink_mask_i,
`endif
        output busy_o, out_valid_o, out_addr_o, out_data_o, out_last_o, done_o
    );

    modport master (
        output load_i, digits_i, dp_i, hex_mode_i, lzb_i, out_ready_i,
`ifdef SEG_BLINK_EN
        output blink_mask_i,
`endif
        input  busy_o, out_valid_o, out_addr_o, out_data_o, out_last_o, done_o
    );
endinterface

// File: rtl/seg_glyph_rom.sv
// Nibble to 7-segment glyph; A..F only in hex mode, otherwise a dash marks an out-of-range digit.
import seg_pkg::*;

module seg_glyph_rom (
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output logic [7:0] o_glyph
);
    always_comb begin
        o_glyph = GLYPH_DASH;
        case (i_nibble)
            4'd0:  o_glyph = GLYPH_0;
            4'd1:  o_glyph = GLYPH_1;
            4'd2:  o_glyph = GLYPH_2;
            4'd3:  o_glyph = GLYPH_3;
            4'd4:  o_glyph = GLYPH_4;
            4'd5:  o_glyph = GLYPH_5;
            4'd6:  o_glyph = GLYPH_6;
            4'd7:  o_glyph = GLYPH_7;
            4'd8:  o_glyph = GLYPH_8;
            4'd9:  o_glyph = GLYPH_9;
            4'd10: o_glyph = i_hex_mode ? GLYPH_A : GLYPH_DASH;
            4'd11: o_glyph = i_hex_mode ? GLYPH_B : GLYPH_DASH;
            4'd12: o_glyph = i_hex_mode ? GLYPH_C : GLYPH_DASH;
            4'd13: o_glyph = i_hex_mode ? GLYPH_D : GLYPH_DASH;
            4'd14: o_glyph = i_hex_mode ? GLYPH_E : GLYPH_DASH;
            default: o_glyph = i_hex_mode ? GLYPH_F : GLYPH_DASH;
        endcase
    end
endmodule

// File: rtl/seg_frame_encoder.sv
// Latches a multi-digit frame and streams one segment byte per digit to the TM1638 driver.
// Optional blink mask enabled by defining SEG_BLINK_EN.
import seg_pkg::*;

module seg_frame_encoder #(
    parameter int DIGITS       = 8,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_frame_encoder_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for load_i, outputs quiet
    // SEND  | streaming beat r_index, held until accepted
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_frame_encoder: DIGITS must be 1..8");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
        $error("seg_frame_encoder: BLINK_CYCLES must be positive");
    end

    state_t              r_state;
    logic [3:0]          r_index;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_dp;
    logic                r_hex;
    logic                r_lzb;
    logic                r_busy, r_valid, r_last, r_done;
    logic [3:0]          r_addr;
    logic [7:0]          r_data;

    logic [4*DIGITS-1:0] w_sel_digits;
    logic [DIGITS-1:0]   w_sel_dp, w_sel_mask;
    logic                w_sel_hex, w_sel_lzb, w_sel_phase;
    logic [3:0]          w_sel_idx;
    logic [3:0]          w_nibble;
    logic                w_dp, w_masked, w_prefix_zero, w_blink_off;
    logic [7:0]          w_glyph, w_byte;

`ifdef SEG_BLINK_EN
    localparam int BCW = $clog2(BLINK_CYCLES + 1);
    logic [BCW-1:0]    r_blink_cnt;
    logic              r_blink_on;
    logic [DIGITS-1:0] r_mask;
    logic              r_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= BCW'(BLINK_CYCLES - 1);
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == '0) begin
            r_blink_cnt <= BCW'(BLINK_CYCLES - 1);
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt - 1'b1;
        end
    end
`endif

    // The output byte is registered, so in IDLE the first beat comes straight from the inputs.
    always_comb begin
        if (r_state == IDLE) begin
            w_sel_digits = bus.digits_i;
            w_sel_dp     = bus.dp_i;
            w_sel_hex    = bus.hex_mode_i;
            w_sel_lzb    = bus.lzb_i;
            w_sel_idx    = 4'd0;
        end else begin
            w_sel_digits = r_digits;
            w_sel_dp     = r_dp;
            w_sel_hex    = r_hex;
            w_sel_lzb    = r_lzb;
            w_sel_idx    = (r_index == LAST_IDX) ? LAST_IDX : r_index + 4'd1;
        end
`ifdef SEG_BLINK_EN
        w_sel_mask  = (r_state == IDLE) ? bus.blink_mask_i : r_mask;
        w_sel_phase = (r_state == IDLE) ? r_blink_on : r_phase;
`else
        w_sel_mask  = '0;
        w_sel_phase = 1'b1;
`endif
    end

    always_comb begin
        w_nibble      = 4'd0;
        w_dp          = 1'b0;
        w_masked      = 1'b0;
        w_prefix_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (4'(j) == w_sel_idx) begin
                w_nibble = w_sel_digits[4*j +: 4];
                w_dp     = w_sel_dp[j];
                w_masked = w_sel_mask[j];
            end
            if (4'(j) <= w_sel_idx && w_sel_digits[4*j +: 4] != 4'd0)
                w_prefix_zero = 1'b0;
        end
    end

    seg_glyph_rom u_glyph_rom (
        .i_nibble   (w_nibble),
        .i_hex_mode (w_sel_hex),
        .o_glyph    (w_glyph)
    );

    assign w_blink_off = w_masked && !w_sel_phase;

    always_comb begin
        if (w_blink_off || (w_sel_lzb && w_prefix_zero && w_sel_idx != LAST_IDX))
            w_byte = GLYPH_BLANK;
        else
            w_byte = w_glyph;
        w_byte[SEG_DP] = w_dp && !w_blink_off;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_index  <= 4'd0;
            r_digits <= '0;
            r_dp     <= '0;
            r_hex    <= 1'b0;
            r_lzb    <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= 8'h00;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SEG_BLINK_EN
            r_mask   <= '0;
            r_phase  <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load_i) begin
                        r_digits <= bus.digits_i;
                        r_dp     <= bus.dp_i;
                        r_hex    <= bus.hex_mode_i;
                        r_lzb    <= bus.lzb_i;
`ifdef SEG_BLINK_EN
                        r_mask   <= bus.blink_mask_i;
                        r_phase  <= r_blink_on;
`endif
                        r_state  <= SEND;
                        r_index  <= 4'd0;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_addr   <= 4'd0;
                        r_data   <= w_byte;
                        r_last   <= (LAST_IDX == 4'd0);
                    end
                end
                SEND: begin
                    if (r_valid && bus.out_ready_i) begin
                        if (r_index == LAST_IDX) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= w_sel_idx;
                            r_addr  <= {w_sel_idx[2:0], 1'b0};
                            r_data  <= w_byte;
                            r_last  <= (w_sel_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.out_valid_o = r_valid;
    assign bus.out_addr_o  = r_addr;
    assign bus.out_data_o  = r_data;
    assign bus.out_last_o  = r_last;
    assign bus.done_o      = r_done;
endmodule

// File: tb/tb_seg_frame_encoder.sv
// Directed bench for seg_frame_encoder (8-digit and 1-digit instances); blink test only with SEG_BLINK_EN.
module tb_seg_frame_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg_frame_encoder_if #(.DIGITS(8)) bus ();
    seg_frame_encoder_if #(.DIGITS(1)) bus1 ();

    seg_frame_encoder #(.DIGITS(8), .BLINK_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    seg_frame_encoder #(.DIGITS(1), .BLINK_CYCLES(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic [3:0] cap_addr [8];
    logic [7:0] cap_data [8];
    logic       cap_last [8];
    int         nb;
    logic       done_seen;

    task automatic load_frame(input logic [31:0] d, input logic [7:0] dp,
                              input logic hex, input logic lzb);
        @(negedge clk);
        bus.digits_i   = d;
        bus.dp_i       = dp;
        bus.hex_mode_i = hex;
        bus.lzb_i      = lzb;
        bus.load_i     = 1'b1;
        @(negedge clk);
        bus.load_i     = 1'b0;
    endtask

    // Records accepted beats; returns at the negedge following the last acceptance.
    task automatic capture(input int n, input int budget);
        nb = 0;
        for (int c = 0; c < budget && nb < n; c++) begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                cap_addr[nb] = bus.out_addr_o;
                cap_data[nb] = bus.out_data_o;
                cap_last[nb] = bus.out_last_o;
                nb++;
            end
            @(negedge clk);
        end
        done_seen = bus.done_o;
    endtask

    task automatic test_reset();
        tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        tests++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid_o); end
        tests++; if (bus.out_addr_o !== 4'd0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus.out_addr_o); end
        tests++; if (bus.out_data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", bus.out_data_o); end
        tests++; if (bus.out_last_o !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", bus.out_last_o); end
        tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    endtask

    task automatic test_decimal();
        logic [7:0] exp_d [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL dec_busy: got %b expected 1", bus.busy_o); end
        capture(8, 40);
        tests++; if (nb !== 8) begin fails++; $display("FAIL dec_count: got %0d expected 8", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_addr[i] !== 4'(2*i)) begin fails++; $display("FAIL dec_addr[%0d]: got %h expected %h", i, cap_addr[i], 4'(2*i)); end
            tests++; if (cap_data[i] !== exp_d[i]) begin fails++; $display("FAIL dec_data[%0d]: got %h expected %h", i, cap_data[i], exp_d[i]); end
            tests++; if (cap_last[i] !== (i == 7)) begin fails++; $display("FAIL dec_last[%0d]: got %b expected %b", i, cap_last[i], (i == 7)); end
        end
        tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL dec_done: got %b expected 1", done_seen); end
        tests++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("FAIL dec_idle: got valid=%b busy=%b expected 0 0", bus.out_valid_o, bus.busy_o); end
        @(negedge clk);
        tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL dec_done_width: got %b expected 0", bus.done_o); end
    endtask

    task automatic test_hex();
        logic [7:0] exp_h [8] = '{8'hEE, 8'h8E, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'hFC, 8'hFC};
        logic [7:0] exp_e [8] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'hFC, 8'hFC};
        load_frame(32'h00EDCBFA, 8'h00, 1'b1, 1'b0);
        capture(8, 40);
        tests++; if (nb !== 8) begin fails++; $display("FAIL hex_count: got %0d expected 8", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_data[i] !== exp_h[i]) begin fails++; $display("FAIL hex_data[%0d]: got %h expected %h", i, cap_data[i], exp_h[i]); end
        end
        load_frame(32'h00EDCBFA, 8'h00, 1'b0, 1'b0);
        capture(8, 40);
        tests++; if (nb !== 8) begin fails++; $display("FAIL err_count: got %0d expected 8", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_data[i] !== exp_e[i]) begin fails++; $display("FAIL err_data[%0d]: got %h expected %h", i, cap_data[i], exp_e[i]); end
        end
    endtask

    task automatic test_lzb();
        logic [7:0] exp_a [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'hFC, 8'hFC};
        logic [7:0] exp_z [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC};
        load_frame(32'h00100000, 8'h01, 1'b0, 1'b1);
        capture(8, 40);
        tests++; if (nb !== 8) begin fails++; $display("FAIL lzb_count: got %0d expected 8", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_data[i] !== exp_a[i]) begin fails++; $display("FAIL lzb_data[%0d]: got %h expected %h", i, cap_data[i], exp_a[i]); end
        end
        load_frame(32'h00000000, 8'h00, 1'b0, 1'b1);
        capture(8, 40);
        tests++; if (nb !== 8) begin fails++; $display("FAIL lzb0_count: got %0d expected 8", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_data[i] !== exp_z[i]) begin fails++; $display("FAIL lzb0_data[%0d]: got %h expected %h", i, cap_data[i], exp_z[i]); end
        end
    endtask

    task automatic test_back_to_back();
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        capture(8, 40);
        tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b expected 1", done_seen); end
        // load in the done cycle must start a new frame
        bus.digits_i = 32'h00000009;
        bus.load_i   = 1'b1;
        @(negedge clk);
        bus.load_i   = 1'b0;
        tests++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 4'd0 || bus.out_data_o !== 8'hF6)
        begin fails++; $display("FAIL b2b_first: got valid=%b addr=%h data=%h expected 1 0 f6", bus.out_valid_o, bus.out_addr_o, bus.out_data_o); end
        capture(8, 40);
        tests++; if (nb !== 8 || done_seen !== 1'b1) begin fails++; $display("FAIL b2b_drain: got beats=%0d done=%b expected 8 1", nb, done_seen); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [6] = '{8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 4'd4 || bus.out_data_o !== 8'hF2 || bus.out_last_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got valid=%b addr=%h data=%h last=%b busy=%b expected 1 4 f2 0 1",
                         c, bus.out_valid_o, bus.out_addr_o, bus.out_data_o, bus.out_last_o, bus.busy_o);
            end
            if (c == 1) begin bus.digits_i = 32'h11111111; bus.load_i = 1'b1; end
            if (c == 2) bus.load_i = 1'b0;
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        capture(6, 30);
        tests++; if (nb !== 6) begin fails++; $display("FAIL stall_count: got %0d expected 6", nb); end
        for (int i = 0; i < nb; i++) begin
            tests++; if (cap_addr[i] !== 4'(2*i + 4) || cap_data[i] !== exp_d[i])
            begin fails++; $display("FAIL stall_beat[%0d]: got %h/%h expected %h/%h", i, cap_addr[i], cap_data[i], 4'(2*i + 4), exp_d[i]); end
        end
        tests++; if (done_seen !== 1'b1) begin fails++; $display("FAIL stall_done: got %b expected 1", done_seen); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        capture(4, 20);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.out_data_o !== 8'h00 || bus.out_addr_o !== 4'd0)
        begin fails++; $display("FAIL mid_reset: got valid=%b busy=%b done=%b data=%h addr=%h expected 0 0 0 00 0",
                                bus.out_valid_o, bus.busy_o, bus.done_o, bus.out_data_o, bus.out_addr_o); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++; if (bus.done_o !== 1'b0 || bus.out_valid_o !== 1'b0)
            begin fails++; $display("FAIL mid_quiet[%0d]: got done=%b valid=%b expected 0 0", c, bus.done_o, bus.out_valid_o); end
        end
        load_frame(32'h00000005, 8'h00, 1'b0, 1'b0);
        tests++; if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 4'd0 || bus.out_data_o !== 8'hB6)
        begin fails++; $display("FAIL mid_restart: got valid=%b addr=%h data=%h expected 1 0 b6", bus.out_valid_o, bus.out_addr_o, bus.out_data_o); end
        capture(8, 40);
        @(negedge clk);
    endtask

    task automatic test_single_digit();
        @(negedge clk);
        bus1.digits_i = 4'h3;
        bus1.dp_i     = 1'b1;
        bus1.lzb_i    = 1'b1;
        bus1.load_i   = 1'b1;
        @(negedge clk);
        bus1.load_i   = 1'b0;
        tests++; if (bus1.out_valid_o !== 1'b1 || bus1.out_addr_o !== 4'd0 || bus1.out_data_o !== 8'hF3 || bus1.out_last_o !== 1'b1)
        begin fails++; $display("FAIL one_beat: got valid=%b addr=%h data=%h last=%b expected 1 0 f3 1",
                                bus1.out_valid_o, bus1.out_addr_o, bus1.out_data_o, bus1.out_last_o); end
        @(negedge clk);
        tests++; if (bus1.done_o !== 1'b1 || bus1.out_valid_o !== 1'b0)
        begin fails++; $display("FAIL one_done: got done=%b valid=%b expected 1 0", bus1.done_o, bus1.out_valid_o); end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        logic [7:0] d2a, d2b, d3a, d3b;
        bus.blink_mask_i = 8'h04;
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        capture(8, 40);
        d2a = cap_data[2]; d3a = cap_data[3];
        // second load lands 12 cycles after the first: three toggles, opposite phase
        @(negedge clk);
        @(negedge clk);
        load_frame(32'h87654321, 8'h00, 1'b0, 1'b0);
        capture(8, 40);
        d2b = cap_data[2]; d3b = cap_data[3];
        tests++; if (!((d2a === 8'hF2 && d2b === 8'h00) || (d2a === 8'h00 && d2b === 8'hF2)))
        begin fails++; $display("FAIL blink_digit2: got %h,%h expected one f2 and one 00", d2a, d2b); end
        tests++; if (d3a !== 8'h66 || d3b !== 8'h66)
        begin fails++; $display("FAIL blink_unmasked: got %h,%h expected 66,66", d3a, d3b); end
        bus.blink_mask_i = 8'h00;
    endtask
`endif

    initial begin
        bus.load_i = 1'b0; bus.digits_i = '0; bus.dp_i = '0;
        bus.hex_mode_i = 1'b0; bus.lzb_i = 1'b0; bus.out_ready_i = 1'b1;
        bus1.load_i = 1'b0; bus1.digits_i = '0; bus1.dp_i = '0;
        bus1.hex_mode_i = 1'b0; bus1.lzb_i = 1'b0; bus1.out_ready_i = 1'b1;
`ifdef SEG_BLINK_EN
        bus.blink_mask_i = '0;
        bus1.blink_mask_i = '0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_decimal();
        test_hex();
        test_lzb();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_single_digit();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
